// File: rtl/demultiplexor_1a4_registrado.sv
// Registered 1-to-4 demultiplexer with a valid/ready handshake on the input
// and on each of the four output lanes. Every lane has a 1-deep holding
// register, so a stalled consumer only blocks words addressed to it.
// Selector coding: 001=A, 010=B, 011=C, 100=D; 000 and 101..111 are invalid
// and such words are accepted and discarded.
// Optional feature: define DEMUX_CONTADOR_ERRORES_EN to count discarded
// invalid-selector words in Errores (saturating); otherwise Errores is 0.
//
// Per-lane state table:
//   state | meaning
//   VACIO | lane holds no word, Salida_valido[i]=0
//   LLENO | lane holds a word for its consumer, Salida_valido[i]=1

module demultiplexor_1a4_registrado #(
    parameter int ANCHO     = 3,
    parameter int ANCHO_ERR = 8
) (
    input  logic                   Reloj,
    input  logic                   Reset,
    input  logic [ANCHO-1:0]       Entrada,
    input  logic [2:0]             Selector,
    input  logic                   Entrada_valido,
    output logic                   Entrada_listo,
    output logic [4*ANCHO-1:0]     Salida,
    output logic [3:0]             Salida_valido,
    input  logic [3:0]             Salida_listo,
    output logic [ANCHO_ERR-1:0]   Errores
);

    typedef enum logic {
        VACIO = 1'b0,
        LLENO = 1'b1
    } estado_t;

    estado_t     estado      [4];
    estado_t     estado_sig  [4];
    logic        sel_valido;
    logic [1:0]  carril;
    logic [3:0]  destino;
    logic [3:0]  carga;
    logic [3:0]  vaciado;

    // Decode the selector into a lane index and a one-hot destination.
    always_comb begin
        sel_valido = 1'b0;
        carril     = 2'd0;
        destino    = 4'b0000;
        case (Selector)
            3'b001:  begin sel_valido = 1'b1; carril = 2'd0; destino = 4'b0001; end
            3'b010:  begin sel_valido = 1'b1; carril = 2'd1; destino = 4'b0010; end
            3'b011:  begin sel_valido = 1'b1; carril = 2'd2; destino = 4'b0100; end
            3'b100:  begin sel_valido = 1'b1; carril = 2'd3; destino = 4'b1000; end
            default: begin sel_valido = 1'b0; carril = 2'd0; destino = 4'b0000; end
        endcase
    end

    // Ready depends only on the selected lane's occupancy and its consumer,
    // never on Entrada_valido; invalid selectors are always accepted.
    always_comb begin
        Entrada_listo = 1'b1;
        if (sel_valido) begin
            Entrada_listo = !Salida_valido[carril] || Salida_listo[carril];
        end
    end

    // Per-lane fill/drain events and the lane status outputs.
    always_comb begin
        carga         = 4'b0000;
        vaciado       = 4'b0000;
        Salida_valido = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            Salida_valido[i] = (estado[i] == LLENO);
            carga[i]         = Entrada_valido && Entrada_listo && destino[i];
            vaciado[i]       = Salida_valido[i] && Salida_listo[i];
        end
    end

    // Next-state: a fill always leaves the lane LLENO, even when it drains
    // on the same edge, so back-to-back words see no bubble.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            estado_sig[i] = estado[i];
            case (estado[i])
                VACIO: begin
                    if (carga[i]) estado_sig[i] = LLENO;
                end
                LLENO: begin
                    if (carga[i])        estado_sig[i] = LLENO;
                    else if (vaciado[i]) estado_sig[i] = VACIO;
                end
                default: estado_sig[i] = VACIO;
            endcase
        end
    end

    // Lane state registers; reset takes priority over any transfer.
    always_ff @(posedge Reloj) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) estado[i] <= VACIO;
        end else begin
            for (int i = 0; i < 4; i++) estado[i] <= estado_sig[i];
        end
    end

    // Lane data registers; a lane keeps its last word after draining.
    always_ff @(posedge Reloj) begin
        if (Reset) begin
            Salida <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (carga[i]) Salida[i*ANCHO +: ANCHO] <= Entrada;
            end
        end
    end

`ifdef DEMUX_CONTADOR_ERRORES_EN
    logic descarte;

    // An invalid-selector transfer is always accepted, so valid alone marks it.
    always_comb begin
        descarte = Entrada_valido && !sel_valido;
    end

    // Saturating count of discarded words.
    always_ff @(posedge Reloj) begin
        if (Reset) begin
            Errores <= '0;
        end else if (descarte && (Errores != {ANCHO_ERR{1'b1}})) begin
            Errores <= Errores + ANCHO_ERR'(1);
        end
    end
`else
    assign Errores = '0;
`endif

endmodule

// File: tb/tb_demultiplexor_1a4_registrado.sv
// Self-checking bench for demultiplexor_1a4_registrado: directed scenarios
// followed by random traffic, all compared against a lane-occupancy model.
module tb_demultiplexor_1a4_registrado;

    localparam int ANCHO     = 3;
    localparam int ANCHO_ERR = 8;
    localparam int ERR_MAX   = (1 << ANCHO_ERR) - 1;

    logic                 Reloj = 1'b0;
    logic                 Reset;
    logic [ANCHO-1:0]     Entrada;
    logic [2:0]           Selector;
    logic                 Entrada_valido;
    logic                 Entrada_listo;
    logic [4*ANCHO-1:0]   Salida;
    logic [3:0]           Salida_valido;
    logic [3:0]           Salida_listo;
    logic [ANCHO_ERR-1:0] Errores;

    demultiplexor_1a4_registrado #(.ANCHO(ANCHO), .ANCHO_ERR(ANCHO_ERR)) dut (
        .Reloj          (Reloj),
        .Reset          (Reset),
        .Entrada        (Entrada),
        .Selector       (Selector),
        .Entrada_valido (Entrada_valido),
        .Entrada_listo  (Entrada_listo),
        .Salida         (Salida),
        .Salida_valido  (Salida_valido),
        .Salida_listo   (Salida_listo),
        .Errores        (Errores)
    );

    always #5 Reloj = ~Reloj;

`ifdef DEMUX_CONTADOR_ERRORES_EN
    localparam bit CON_CONTADOR = 1'b1;
`else
    localparam bit CON_CONTADOR = 1'b0;
`endif

    int vectores = 0;
    int fallos   = 0;

    // Reference model: which lanes hold a word, what word, and error count.
    bit             m_lleno [4];
    logic [ANCHO-1:0] m_dato [4];
    int             m_err;
    bit             m_init = 1'b0;

    task automatic comparar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        vectores++;
        assert (obs === esp) else begin
            fallos++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, esp);
        end
    endtask

    function automatic bit sel_ok(input logic [2:0] s);
        return (s >= 3'd1) && (s <= 3'd4);
    endfunction

    function automatic logic listo_esperado(input logic [2:0] s, input logic [3:0] ol);
        int t;
        if (!sel_ok(s)) return 1'b1;
        t = int'(s) - 1;
        return !m_lleno[t] || ol[t];
    endfunction

    function automatic logic [4*ANCHO-1:0] salida_esperada();
        logic [4*ANCHO-1:0] v;
        for (int i = 0; i < 4; i++) v[i*ANCHO +: ANCHO] = m_dato[i];
        return v;
    endfunction

    function automatic logic [3:0] valido_esperado();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_lleno[i];
        return v;
    endfunction

    // One clock of stimulus: drive at negedge, check ready, clock, check outputs.
    task automatic paso(input logic rst, input logic [ANCHO-1:0] din, input logic [2:0] sel,
                        input logic v, input logic [3:0] ol);
        logic acepta;
        int   t;
        @(negedge Reloj);
        Reset          = rst;
        Entrada        = din;
        Selector       = sel;
        Entrada_valido = v;
        Salida_listo   = ol;
        #1;
        if (m_init) comparar("entrada_listo", 32'(Entrada_listo), 32'(listo_esperado(sel, ol)));
        acepta = v && listo_esperado(sel, ol);
        @(posedge Reloj);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_lleno[i] = 1'b0;
                m_dato[i]  = '0;
            end
            m_err  = 0;
            m_init = 1'b1;
        end else if (m_init) begin
            for (int i = 0; i < 4; i++) if (m_lleno[i] && ol[i]) m_lleno[i] = 1'b0;
            if (acepta && sel_ok(sel)) begin
                t = int'(sel) - 1;
                m_lleno[t] = 1'b1;
                m_dato[t]  = din;
            end
            if (acepta && !sel_ok(sel) && CON_CONTADOR && m_err < ERR_MAX) m_err++;
        end
        #1;
        if (m_init) begin
            comparar("salida_valido", 32'(Salida_valido), 32'(valido_esperado()));
            comparar("salida",        32'(Salida),        32'(salida_esperada()));
            comparar("errores",       32'(Errores),       32'(m_err));
        end
    endtask

    initial begin
        Reset = 1'b1; Entrada = '0; Selector = 3'd0; Entrada_valido = 1'b0; Salida_listo = 4'b0000;

        // Reset for two cycles.
        paso(1'b1, 3'd0, 3'd0, 1'b0, 4'b1111);
        paso(1'b1, 3'd0, 3'd0, 1'b0, 4'b1111);
        comparar("reset_listo", 32'(Entrada_listo), 32'd1);

        // Single word to B, drains on the following cycle.
        paso(1'b0, 3'd5, 3'b010, 1'b1, 4'b1111);
        comparar("b_cargado", 32'(Salida_valido), 32'b0010);
        paso(1'b0, 3'd0, 3'd0, 1'b0, 4'b1111);

        // Lane A stalled: second word refused, then drain and load together.
        paso(1'b0, 3'd1, 3'b001, 1'b1, 4'b1110);
        paso(1'b0, 3'd2, 3'b001, 1'b1, 4'b1110);
        comparar("a_retiene", 32'(Salida[ANCHO-1:0]), 32'd1);
        paso(1'b0, 3'd2, 3'b001, 1'b1, 4'b1111);
        comparar("a_reemplazo", 32'(Salida[ANCHO-1:0]), 32'd2);

        // A stalled and full again; D still accepts.
        paso(1'b0, 3'd3, 3'b001, 1'b1, 4'b1110);
        paso(1'b0, 3'd7, 3'b100, 1'b1, 4'b1110);
        comparar("d_siete", 32'(Salida[3*ANCHO +: ANCHO]), 32'd7);

        // Invalid selectors: accepted, lanes untouched.
        paso(1'b0, 3'd6, 3'b000, 1'b1, 4'b0000);
        paso(1'b0, 3'd6, 3'b111, 1'b1, 4'b0000);
        comparar("errores_dos", 32'(Errores), CON_CONTADOR ? 32'd2 : 32'd0);

        // Reset wins over a pending transfer while B and C are full.
        paso(1'b0, 3'd3, 3'b010, 1'b1, 4'b0000);
        paso(1'b0, 3'd4, 3'b011, 1'b1, 4'b0000);
        paso(1'b1, 3'd5, 3'b010, 1'b1, 4'b0000);
        comparar("reset_gana", 32'(Salida_valido), 32'b0000);

        // Random traffic, biased toward valid selectors, occasional reset.
        for (int n = 0; n < 600; n++) begin
            logic [2:0] s;
            s = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
            paso(($urandom_range(0, 49) == 0), 3'($urandom), s,
                 ($urandom_range(0, 3) != 0), 4'($urandom));
        end

        // Counter saturation.
        if (CON_CONTADOR) begin
            paso(1'b1, 3'd0, 3'd0, 1'b0, 4'b1111);
            for (int n = 0; n < ERR_MAX + 5; n++) paso(1'b0, 3'($urandom), 3'b110, 1'b1, 4'($urandom));
            comparar("saturacion", 32'(Errores), 32'(ERR_MAX));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
        $finish;
    end

endmodule
